// File: rtl/ofmap_pkg.sv
// Shared definitions for the OFMAP writer: FSM encoding, default widths, frame sizing.
// Optional build macro used by this slice: OFMAP_RELU_EN (see ofmap_writer).
package ofmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_TILING_SIZE = 8;
    localparam int DEF_NUM_TILES   = 64;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int SEL_WIDTH       = 4;

    function automatic int frame_total(input int num_tiles, input int tiling_size);
        return num_tiles * tiling_size;
    endfunction

endpackage

// File: rtl/ofmap_if.sv
// Element stream in from the tile write sequencer and SRAM write port out of the OFMAP writer.
interface ofmap_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  valid_in;
    logic [3:0]            sel_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  mem_ready;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Environment side: drives the element stream and the SRAM ready.
    modport master (
        output valid_in, sel_in, data_in, mem_ready,
        input  mem_wr_en, mem_addr, mem_wdata
    );

    // Writer side.
    modport slave (
        input  valid_in, sel_in, data_in, mem_ready,
        output mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ofmap_fifo.sv
// Show-ahead synchronous FIFO; head is valid whenever empty is low.
module ofmap_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           wr_ptr_r;
    logic [PW:0]           rd_ptr_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                   (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign head  = mem_r[rd_ptr_r[PW-1:0]];

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ofmap_writer.sv
// Buffers the tile element stream and writes it to OFMAP SRAM at base_addr + element count.
// Build option OFMAP_RELU_EN: clamp negative (signed) elements to zero before buffering.
module ofmap_writer
    import ofmap_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TILING_SIZE = DEF_TILING_SIZE,
    parameter int NUM_TILES   = DEF_NUM_TILES,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    ofmap_if.slave                bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  seq_err
);
    localparam int TOTAL = frame_total(NUM_TILES, TILING_SIZE);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0]        TOTAL_C  = CW'(TOTAL);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(TILING_SIZE - 1);

    state_e                 state_r;
    state_e                 state_s;
    logic [CW-1:0]          push_cnt_r;
    logic [CW-1:0]          wr_cnt_r;
    logic [CW-1:0]          push_cnt_s;
    logic [CW-1:0]          wr_cnt_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [SEL_WIDTH-1:0]   idx_r;
    logic                   overflow_r;
    logic                   seq_err_r;
    logic                   in_run_s;
    logic                   active_s;
    logic                   wr_en_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   sel_bad_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [DATA_WIDTH-1:0]  fifo_head_s;
    logic [DATA_WIDTH-1:0]  push_data_s;

    ofmap_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_data_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // Push/pop/drop decode and next counter values.
    always_comb begin
        in_run_s   = (state_r == ST_RUN);
        active_s   = in_run_s || (state_r == ST_DRAIN);
        wr_en_s    = active_s && !fifo_empty_s;
        pop_s      = wr_en_s && bus.mem_ready;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        if (bus.valid_in) begin
            if (in_run_s) begin
                push_s = !fifo_full_s || pop_s;
                drop_s = fifo_full_s && !pop_s;
            end else begin
                drop_s = (state_r == ST_DRAIN);
            end
        end else begin
            push_s = 1'b0;
        end
        sel_bad_s  = (bus.sel_in != (idx_r + SEL_WIDTH'(1)));
        push_cnt_s = push_cnt_r + CW'(push_s);
        wr_cnt_s   = wr_cnt_r + CW'(pop_s);
    end

    // Optional ReLU clamp ahead of the buffer.
    always_comb begin
        push_data_s = bus.data_in;
`ifdef OFMAP_RELU_EN
        if (bus.data_in[DATA_WIDTH-1]) begin
            push_data_s = '0;
        end else begin
            push_data_s = bus.data_in;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((push_cnt_s == TOTAL_C) && (wr_cnt_s == TOTAL_C)) begin
                    state_s = ST_DONE;
                end else if (push_cnt_s == TOTAL_C) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_s == TOTAL_C) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, address generator and sticky flags; a honoured start reinitialises the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_r <= '0;
            wr_cnt_r   <= '0;
            addr_r     <= '0;
            idx_r      <= '0;
            overflow_r <= 1'b0;
            seq_err_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            push_cnt_r <= '0;
            wr_cnt_r   <= '0;
            addr_r     <= base_addr;
            idx_r      <= '0;
            overflow_r <= 1'b0;
            seq_err_r  <= 1'b0;
        end else begin
            push_cnt_r <= push_cnt_s;
            wr_cnt_r   <= wr_cnt_s;
            if (pop_s) begin
                addr_r <= addr_r + ADDR_WIDTH'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            // Expected index follows the push count, so one bad sel does not cascade.
            if (push_s) begin
                if (sel_bad_s) begin
                    seq_err_r <= 1'b1;
                end
                if (idx_r == LAST_IDX) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + SEL_WIDTH'(1);
                end
            end
        end
    end

    assign bus.mem_wr_en = wr_en_s;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wr_en_s ? fifo_head_s : '0;
    assign busy          = active_s;
    assign frame_done    = (state_r == ST_DONE);
    assign overflow      = overflow_r;
    assign seq_err       = seq_err_r;

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed, table-driven bench for ofmap_writer with small frame parameters (4 x 2 elements, FIFO depth 4).
module tb_ofmap_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        seq_err;

    int checks   = 0;
    int failures = 0;

`ifdef OFMAP_RELU_EN
    localparam logic [15:0] RELU_EXP = 16'h0000;
`else
    localparam logic [15:0] RELU_EXP = 16'h8003;
`endif

    ofmap_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    ofmap_writer #(
        .DATA_WIDTH  (16),
        .TILING_SIZE (4),
        .NUM_TILES   (2),
        .ADDR_WIDTH  (16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic        valid;
        logic [3:0]  sel;
        logic [15:0] data;
        logic        ready;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        logic        e_seq;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [15:0] base, input logic valid,
                       input logic [3:0] sel, input logic [15:0] data, input logic ready,
                       input logic e_wr, input logic [15:0] e_addr, input logic [15:0] e_wdata,
                       input logic e_busy, input logic e_done, input logic e_ovf,
                       input logic e_seq, input logic e_full);
        vec_t v;
        v.st = st; v.base = base; v.valid = valid; v.sel = sel; v.data = data; v.ready = ready;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_busy = e_busy;
        v.e_done = e_done; v.e_ovf = e_ovf; v.e_seq = e_seq; v.e_full = e_full;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_en"}, 16'(bus.mem_wr_en), 16'h0);
        chk({tag, "_addr"},  bus.mem_addr,       16'h0);
        chk({tag, "_wdata"}, bus.mem_wdata,      16'h0);
        chk({tag, "_busy"},  16'(busy),          16'h0);
        chk({tag, "_done"},  16'(frame_done),    16'h0);
        chk({tag, "_ovf"},   16'(overflow),      16'h0);
        chk({tag, "_seq"},   16'(seq_err),       16'h0);
    endtask

    initial begin
        int seqsel[8];
        seqsel = '{1, 2, 4, 4, 1, 2, 3, 4};

        // Basic frame, mem_ready held high.
        add(1'b1, 16'h0100, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 16'h0, 1'b1, 4'((k % 4) + 1), 16'h1000 + 16'(k), 1'b1,
                1'b1, 16'h0100 + 16'(k), 16'h1000 + 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0108, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0108, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: fill the FIFO with mem_ready low, then drain and finish.
        add(1'b1, 16'h0200, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0200, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b1, 4'(k + 1), 16'h2000 + 16'(k), 1'b0,
                1'b1, 16'h0200, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0, (k == 3));
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1,
                (k < 3), 16'h0201 + 16'(k), (k < 3) ? 16'h2001 + 16'(k) : 16'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b1, 4'(k + 1), 16'h2004 + 16'(k), 1'b1,
                1'b1, 16'h0204 + 16'(k), 16'h2004 + 16'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0208, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0208, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sequence error at the third push; element still written at base+2.
        add(1'b1, 16'h0300, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 16'h0, 1'b1, 4'(seqsel[k]), 16'h3000 + 16'(k), 1'b1,
                1'b1, 16'h0300 + 16'(k), 16'h3000 + 16'(k), 1'b1, 1'b0, 1'b0, (k >= 2), 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0308, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0308, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overflow: 5th element dropped; start while busy ignored; frame only ends after 4 more elements.
        add(1'b1, 16'h0400, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0400, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b1, 4'(k + 1), 16'h4000 + 16'(k), 1'b0,
                1'b1, 16'h0400, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, (k == 3));
        add(1'b0, 16'h0, 1'b1, 4'd1, 16'h4004, 1'b0, 1'b1, 16'h0400, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 16'h0500, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 16'h0400, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1,
                (k < 3), 16'h0401 + 16'(k), (k < 3) ? 16'h4001 + 16'(k) : 16'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b0, 16'h0, 1'b1, 4'(k + 1), 16'h4010 + 16'(k), 1'b1,
                1'b1, 16'h0404 + 16'(k), 16'h4010 + 16'(k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0408, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0408, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state.
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 16'h0;
        bus.valid_in = 1'b0;
        bus.sel_in = 4'd0;
        bus.data_in = 16'h0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("post_reset");

        // Table replay: inputs applied after an edge, outputs compared just after the next edge.
        for (int i = 0; i < vecs.size(); i++) begin
            start         = vecs[i].st;
            base_addr     = vecs[i].base;
            bus.valid_in  = vecs[i].valid;
            bus.sel_in    = vecs[i].sel;
            bus.data_in   = vecs[i].data;
            bus.mem_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_wr_en", i), 16'(bus.mem_wr_en),   16'(vecs[i].e_wr));
            chk($sformatf("row%0d_addr", i),  bus.mem_addr,         vecs[i].e_addr);
            chk($sformatf("row%0d_wdata", i), bus.mem_wdata,        vecs[i].e_wdata);
            chk($sformatf("row%0d_busy", i),  16'(busy),            16'(vecs[i].e_busy));
            chk($sformatf("row%0d_done", i),  16'(frame_done),      16'(vecs[i].e_done));
            chk($sformatf("row%0d_ovf", i),   16'(overflow),        16'(vecs[i].e_ovf));
            chk($sformatf("row%0d_seq", i),   16'(seq_err),         16'(vecs[i].e_seq));
            chk($sformatf("row%0d_full", i),  16'(dut.u_fifo.full), 16'(vecs[i].e_full));
        end
        start = 1'b0;
        bus.valid_in = 1'b0;

        // Address wrap at the top of the SRAM, ReLU element, then abort by reset mid-frame.
        start = 1'b1;
        base_addr = 16'hFFFE;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("wrap_start_addr", bus.mem_addr, 16'hFFFE);
        chk("wrap_start_busy", 16'(busy), 16'h1);
        chk("wrap_start_ovf_cleared", 16'(overflow), 16'h0);
        bus.valid_in = 1'b1;
        bus.sel_in = 4'd1;
        bus.data_in = 16'h8003;
        @(posedge clk);
        #1;
        chk("wrap0_addr", bus.mem_addr, 16'hFFFE);
        chk("relu_wdata", bus.mem_wdata, RELU_EXP);
        bus.sel_in = 4'd2;
        bus.data_in = 16'h5001;
        @(posedge clk);
        #1;
        chk("wrap1_addr", bus.mem_addr, 16'hFFFF);
        chk("wrap1_wdata", bus.mem_wdata, 16'h5001);
        bus.sel_in = 4'd3;
        bus.data_in = 16'h5002;
        @(posedge clk);
        #1;
        chk("wrap2_addr", bus.mem_addr, 16'h0000);
        chk("wrap2_wdata", bus.mem_wdata, 16'h5002);
        chk("wrap2_wr_en", 16'(bus.mem_wr_en), 16'h1);
        bus.valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        @(negedge clk);
        chk_outputs_zero("abort_cycle");
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_no_done%0d", c), 16'(frame_done), 16'h0);
            chk($sformatf("abort_no_wr%0d", c), 16'(bus.mem_wr_en), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
